// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-subset decode stage: IF/ID register, register file, branch resolve, hazards, ID/EX register
module decode_stage #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] pcAddFour,
  input  logic [Width-1:0] instruction,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_writeReg,
  input  logic [Width-1:0] wb_writeData,
  input  logic             mem_regWrite,
  input  logic [4:0]       mem_writeReg,
  output logic             pc_enable,
  output logic             PCSrc,
  output logic [Width-1:0] adderResult,
  output logic             ex_valid,
  output logic [5:0]       ex_opcode,
  output logic [5:0]       ex_funct,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [Width-1:0] ex_readData1,
  output logic [Width-1:0] ex_readData2,
  output logic [Width-1:0] ex_signImm,
  output logic [Width-1:0] ex_pcAddFour
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  logic [Width-1:0] id_instr;
  logic [Width-1:0] id_pc4;
  logic             id_valid;
  logic [Width-1:0] rf [32];

  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [Width-1:0] id_sign_imm;
  logic [Width-1:0] read_data1;
  logic [Width-1:0] read_data2;

  logic [4:0] ex_dest;
  logic       ex_wr;
  logic       is_beq;
  logic       is_bne;
  logic       operands_equal;
  logic       dep_rs;
  logic       dep_rt;
  logic       load_use;
  logic       branch_dep;
  logic       stall;
  logic       taken;

  assign id_opcode   = id_instr[31:26];
  assign id_rs       = id_instr[25:21];
  assign id_rt       = id_instr[20:16];
  assign id_rd       = id_instr[15:11];
  assign id_funct    = id_instr[5:0];
  assign id_sign_imm = {{(Width-16){id_instr[15]}}, id_instr[15:0]};

  // Write-through lets the instruction in ID see a value retiring in WB this cycle.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (id_rs != 5'd0) begin
      read_data1 = (wb_regWrite && wb_writeReg == id_rs) ? wb_writeData : rf[id_rs];
    end
    if (id_rt != 5'd0) begin
      read_data2 = (wb_regWrite && wb_writeReg == id_rt) ? wb_writeData : rf[id_rt];
    end
  end

  always_comb begin
    ex_dest = 5'd0;
    if (ex_valid) begin
      if (ex_opcode == OP_RTYPE) begin
        ex_dest = ex_rd;
      end else if (ex_opcode == OP_LW || ex_opcode[5:3] == 3'b001) begin
        ex_dest = ex_rt;
      end
    end
  end

  assign ex_wr = (ex_dest != 5'd0);

  assign dep_rs = (id_rs != 5'd0) &&
                  ((ex_wr && ex_dest == id_rs) || (mem_regWrite && mem_writeReg == id_rs));
  assign dep_rt = (id_rt != 5'd0) &&
                  ((ex_wr && ex_dest == id_rt) || (mem_regWrite && mem_writeReg == id_rt));

  assign is_beq = (id_opcode == OP_BEQ);
  assign is_bne = (id_opcode == OP_BNE);

  assign load_use   = ex_valid && (ex_opcode == OP_LW) && (ex_rt != 5'd0) &&
                      (ex_rt == id_rs || ex_rt == id_rt);
  assign branch_dep = id_valid && (is_beq || is_bne) && (dep_rs || dep_rt);
  assign stall      = load_use | branch_dep;

  // A branch blocked on an operand is neither taken nor flushed until the stall clears.
  assign operands_equal = (read_data1 == read_data2);
  assign taken          = id_valid && !stall &&
                          ((is_beq && operands_equal) || (is_bne && !operands_equal));

  assign pc_enable   = ~stall;
  assign PCSrc       = taken;
  assign adderResult = id_pc4 + {id_sign_imm[Width-3:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_regWrite && wb_writeReg != 5'd0) begin
      rf[wb_writeReg] <= wb_writeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (taken) begin
        id_instr <= '0;
        id_pc4   <= pcAddFour;
        id_valid <= 1'b0;
      end else begin
        id_instr <= instruction;
        id_pc4   <= pcAddFour;
        id_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_readData1 <= '0;
      ex_readData2 <= '0;
      ex_signImm   <= '0;
      ex_pcAddFour <= '0;
    end else if (stall) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_funct     <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rd        <= '0;
      ex_readData1 <= '0;
      ex_readData2 <= '0;
      ex_signImm   <= '0;
      ex_pcAddFour <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_opcode    <= id_opcode;
      ex_funct     <= id_funct;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_readData1 <= read_data1;
      ex_readData2 <= read_data2;
      ex_signImm   <= id_sign_imm;
      ex_pcAddFour <= id_pc4;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized and directed bench for decode_stage against a behavioural model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcAddFour, instruction, wb_writeData;
  logic        wb_regWrite, mem_regWrite;
  logic [4:0]  wb_writeReg, mem_writeReg;
  logic        pc_enable, PCSrc, ex_valid;
  logic [31:0] adderResult, ex_readData1, ex_readData2, ex_signImm, ex_pcAddFour;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  decode_stage #(.Width(32)) dut (
    .clk(clk), .rst_n(rst_n), .pcAddFour(pcAddFour), .instruction(instruction),
    .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
    .mem_regWrite(mem_regWrite), .mem_writeReg(mem_writeReg),
    .pc_enable(pc_enable), .PCSrc(PCSrc), .adderResult(adderResult),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
    .ex_signImm(ex_signImm), .ex_pcAddFour(ex_pcAddFour)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADD9  = 32'h01084820; // add $9,$8,$8
  localparam logic [31:0] LW2   = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] ADD3  = 32'h00441820; // add $3,$2,$4
  localparam logic [31:0] BEQ3  = 32'h10220003; // beq $1,$2,3
  localparam logic [31:0] ADDI  = 32'h20230001; // addi $3,$1,1
  localparam logic [31:0] BNEM1 = 32'h1422FFFF; // bne $1,$2,-1
  localparam logic [31:0] LW1   = 32'h8C610000; // lw  $1,0($3)
  localparam logic [31:0] BEQ2  = 32'h10220002; // beq $1,$2,2
  localparam logic [31:0] ADD6  = 32'h00A03020; // add $6,$5,$0

  int total = 0;
  int bad = 0;

  // Reference state: architectural registers, the instruction waiting in decode, and the issued bundle.
  logic [31:0] m_rf [32];
  logic [31:0] m_id_instr, m_id_pc4;
  logic        m_id_valid;
  logic        me_valid;
  logic [5:0]  me_op, me_funct;
  logic [4:0]  me_rs, me_rt, me_rd;
  logic [31:0] me_d1, me_d2, me_imm, me_pc4;
  logic        e_stall, e_taken;
  logic [31:0] e_a, e_b, e_tgt;

  logic        o_pce, o_pcsrc, o_exv;
  logic [31:0] o_tgt, o_d1, o_d2, o_pc4;
  logic [4:0]  o_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_regWrite && wb_writeReg == r) return wb_writeData;
    return m_rf[r];
  endfunction

  function automatic logic [4:0] m_ex_dest();
    if (!me_valid) return 5'd0;
    if (me_op == 6'd0) return me_rd;
    if (me_op == 6'd35 || (me_op >= 6'd8 && me_op <= 6'd15)) return me_rt;
    return 5'd0;
  endfunction

  function automatic logic m_depends(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (m_ex_dest() == r) || (mem_regWrite && mem_writeReg == r);
  endfunction

  task automatic model_eval();
    int op, rs, rt;
    logic lu, bd;
    op = int'(m_id_instr[31:26]);
    rs = int'(m_id_instr[25:21]);
    rt = int'(m_id_instr[20:16]);
    lu = me_valid && me_op == 6'd35 && me_rt != 0 && (int'(me_rt) == rs || int'(me_rt) == rt);
    bd = m_id_valid && (op == 4 || op == 5) &&
         (m_depends(5'(rs)) || m_depends(5'(rt)));
    e_stall = lu || bd;
    e_a = mread(5'(rs));
    e_b = mread(5'(rt));
    e_taken = m_id_valid && !e_stall && ((op == 4 && e_a == e_b) || (op == 5 && e_a != e_b));
    e_tgt = m_id_pc4 + 32'($signed(m_id_instr[15:0])) * 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_id_instr = 0; m_id_pc4 = 0; m_id_valid = 0;
    me_valid = 0; me_op = 0; me_funct = 0; me_rs = 0; me_rt = 0; me_rd = 0;
    me_d1 = 0; me_d2 = 0; me_imm = 0; me_pc4 = 0;
  endtask

  task automatic model_update();
    if (e_stall) begin
      me_valid = 0; me_op = 0; me_funct = 0; me_rs = 0; me_rt = 0; me_rd = 0;
      me_d1 = 0; me_d2 = 0; me_imm = 0; me_pc4 = 0;
    end else begin
      me_valid = m_id_valid;
      me_op = m_id_instr[31:26]; me_funct = m_id_instr[5:0];
      me_rs = m_id_instr[25:21]; me_rt = m_id_instr[20:16]; me_rd = m_id_instr[15:11];
      me_d1 = e_a; me_d2 = e_b;
      me_imm = 32'($signed(m_id_instr[15:0]));
      me_pc4 = m_id_pc4;
      if (e_taken) begin
        m_id_instr = 0; m_id_valid = 0; m_id_pc4 = 0;
      end else begin
        m_id_instr = instruction; m_id_pc4 = pcAddFour; m_id_valid = 1;
      end
    end
    if (wb_regWrite && wb_writeReg != 0) m_rf[wb_writeReg] = wb_writeData;
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc4,
                      input logic ww, input logic [4:0] wr, input logic [31:0] wd,
                      input logic mw, input logic [4:0] mr);
    instruction = ins; pcAddFour = pc4;
    wb_regWrite = ww; wb_writeReg = wr; wb_writeData = wd;
    mem_regWrite = mw; mem_writeReg = mr;
    @(negedge clk);
    model_eval();
    o_pce = pc_enable; o_pcsrc = PCSrc; o_tgt = adderResult; o_exv = ex_valid;
    o_d1 = ex_readData1; o_d2 = ex_readData2; o_rd = ex_rd; o_pc4 = ex_pcAddFour;
    chk("pc_enable", pc_enable, e_stall ? 0 : 1);
    chk("PCSrc", PCSrc, e_taken);
    if (m_id_valid) chk("adderResult", adderResult, e_tgt);
    chk("ex_valid", ex_valid, me_valid);
    chk("ex_opcode", ex_opcode, me_op);
    chk("ex_funct", ex_funct, me_funct);
    chk("ex_rs", ex_rs, me_rs);
    chk("ex_rt", ex_rt, me_rt);
    chk("ex_rd", ex_rd, me_rd);
    chk("ex_readData1", ex_readData1, me_d1);
    chk("ex_readData2", ex_readData2, me_d2);
    chk("ex_signImm", ex_signImm, me_imm);
    if (me_valid) chk("ex_pcAddFour", ex_pcAddFour, me_pc4);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] pc4);
    step(ins, pc4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ex_valid"}, ex_valid, 0);
    chk({tag, "_ex_opcode"}, ex_opcode, 0);
    chk({tag, "_ex_rd"}, ex_rd, 0);
    chk({tag, "_ex_readData1"}, ex_readData1, 0);
    chk({tag, "_ex_signImm"}, ex_signImm, 0);
    chk({tag, "_ex_pcAddFour"}, ex_pcAddFour, 0);
    chk({tag, "_pc_enable"}, pc_enable, 1);
    chk({tag, "_PCSrc"}, PCSrc, 0);
    chk({tag, "_adderResult"}, adderResult, 0);
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle and releases a cycle later.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic random_step();
    logic [4:0] rs, rt, rd;
    logic [31:0] ins;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: ins = {6'b100011, rs, rt, 16'($urandom)};
      1: ins = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      2: ins = {6'b001000, rs, rt, 16'($urandom)};
      3: ins = {6'b000100, rs, rt, 16'($urandom)};
      4: ins = {6'b000101, rs, rt, 16'($urandom)};
      default: ins = {6'b101011, rs, rt, 16'($urandom)};
    endcase
    step(ins, {$urandom} & 32'hFFFF_FFFC,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
         1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = 0; pcAddFour = 0;
    wb_regWrite = 0; wb_writeReg = 0; wb_writeData = 0;
    mem_regWrite = 0; mem_writeReg = 0;
    model_reset();
    #3 check_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write-through into the ID read port
    fetch(ADD9, 32'h20);
    step(32'd0, 32'h24, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0);
    fetch(32'd0, 32'h28);
    chk("wt_rd1", o_d1, 32'hDEADBEEF);
    chk("wt_rd2", o_d2, 32'hDEADBEEF);

    // Load-use: one stall, one bubble, then the add issues
    fetch(LW2, 32'h10);
    fetch(ADD3, 32'h14);
    fetch(32'd0, 32'h18);
    chk("lu_stall", o_pce, 0);
    fetch(32'd0, 32'h18);
    chk("lu_bubble", o_exv, 0);
    chk("lu_resume", o_pce, 1);
    fetch(32'd0, 32'h1C);
    chk("lu_add_valid", o_exv, 1);
    chk("lu_add_rd", o_rd, 3);
    chk("lu_add_pc4", o_pc4, 32'h14);

    // Taken beq flushes the fall-through
    step(32'd0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
    step(32'd0, 32'd0, 1'b1, 5'd2, 32'd5, 1'b0, 5'd0);
    fetch(BEQ3, 32'h40);
    fetch(ADDI, 32'h44);
    chk("beq_taken", o_pcsrc, 1);
    chk("beq_target", o_tgt, 32'h4C);
    fetch(32'd0, 32'h4C);
    fetch(32'd0, 32'h50);
    chk("beq_flushed", o_exv, 0);

    // bne not taken, negative offset
    fetch(BNEM1, 32'h80);
    fetch(32'd0, 32'h84);
    chk("bne_not_taken", o_pcsrc, 0);
    chk("bne_target", o_tgt, 32'h7C);

    // Branch after lw: stall in EX, stall in MEM, resolve via WB bypass
    step(32'd0, 32'd0, 1'b1, 5'd1, 32'd9, 1'b0, 5'd0);
    fetch(LW1, 32'h100);
    fetch(BEQ2, 32'h104);
    fetch(32'd0, 32'h108);
    chk("bl_stall1", o_pce, 0);
    step(32'd0, 32'h108, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1);
    chk("bl_stall2", o_pce, 0);
    chk("bl_no_take", o_pcsrc, 0);
    step(32'd0, 32'h108, 1'b1, 5'd1, 32'd5, 1'b0, 5'd0);
    chk("bl_go", o_pce, 1);
    chk("bl_taken", o_pcsrc, 1);
    chk("bl_target", o_tgt, 32'h10C);

    // Reset asserted during a load-use stall
    step(32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    fetch(LW2, 32'h10);
    fetch(ADD3, 32'h14);
    chk("rst_pre_stall", pc_enable, 0);
    do_reset("mid_stall");
    fetch(ADD6, 32'h200);
    fetch(32'd0, 32'h204);
    fetch(32'd0, 32'h208);
    chk("rst_r5_zero", o_d1, 0);
    chk("rst_add_valid", o_exv, 1);

    for (int i = 0; i < 1500; i++) random_step();
    do_reset("mid_rand");
    for (int i = 0; i < 1500; i++) random_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
